// File: rtl/pmu_quota_pkg.sv
// Shared definitions for the PMU quota regulator: FSM state encoding and the
// shortest replenishment window the regulator will run.
package pmu_quota_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        RUN       = 2'd2,
        THROTTLED = 2'd3
    } quota_reg_state_t;

    localparam int unsigned MIN_PERIOD = 32'd2;

endpackage

// File: rtl/pmu_period_timer.sv
// Loadable down-counter timing one replenishment window; holds at zero and
// holds its value whenever neither load nor dec is asserted.
module pmu_period_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // next count: load beats decrement, decrement never wraps below zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != {WIDTH{1'b0}})) begin
            count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/pmu_quota_regulator.sv
// Per-core quota regulator: refills the quota monitor every window, throttles
// the core after an overrun, and reports overruns via interrupt and counter.
module pmu_quota_regulator
    import pmu_quota_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [REG_WIDTH-1:0] period_i,
    input  logic                 intr_quota_i,
    input  logic                 ack_i,
    output logic                 quota_softrst_o,
    output logic                 throttle_o,
    output logic                 intr_o,
    output logic [CNT_WIDTH-1:0] overrun_count_o,
    output logic [1:0]           state_o
);

    localparam logic [REG_WIDTH-1:0] MIN_P   = REG_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    quota_reg_state_t     state_q, state_d;
    logic                 softrst_q, softrst_d;
    logic                 throttle_q, throttle_d;
    logic                 intr_q, intr_d;
    logic [CNT_WIDTH-1:0] overrun_count_q, overrun_count_d;

    logic                 timer_load_s;
    logic                 timer_dec_s;
    logic                 timer_zero_s;
    logic                 overrun_s;
    logic [REG_WIDTH-1:0] timer_load_val_s;

    // REFILL itself and the zero-count RUN cycle account for MIN_PERIOD cycles
    assign timer_load_val_s = (period_i < MIN_P) ? {REG_WIDTH{1'b0}} : (period_i - MIN_P);

    pmu_period_timer #(
        .WIDTH (REG_WIDTH)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (timer_load_s),
        .load_val_i (timer_load_val_s),
        .dec_i      (timer_dec_s),
        .zero_o     (timer_zero_s)
    );

    // next-state, timer control and overrun-event detection
    always_comb begin
        state_d      = state_q;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        overrun_s    = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REFILL;
                end
                REFILL: begin
                    timer_load_s = 1'b1;
                    state_d      = RUN;
                end
                RUN: begin
                    if (timer_zero_s) begin
                        // window boundary wins; a late overrun is logged but not throttled
                        state_d   = REFILL;
                        overrun_s = intr_quota_i;
                    end else if (intr_quota_i) begin
                        state_d     = THROTTLED;
                        overrun_s   = 1'b1;
                        timer_dec_s = 1'b1;
                    end else begin
                        timer_dec_s = 1'b1;
                    end
                end
                THROTTLED: begin
                    if (timer_zero_s) begin
                        state_d = REFILL;
                    end else begin
                        timer_dec_s = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // registered output decode from the next state, sticky interrupt, saturating count
    always_comb begin
        softrst_d       = (state_d == REFILL);
        throttle_d      = (state_d == THROTTLED);
        intr_d          = intr_q;
        overrun_count_d = overrun_count_q;
        if (overrun_s) begin
            intr_d = 1'b1;
        end else if (ack_i) begin
            intr_d = 1'b0;
        end else begin
            intr_d = intr_q;
        end
        if (overrun_s && (overrun_count_q != CNT_MAX)) begin
            overrun_count_d = overrun_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            overrun_count_d = overrun_count_q;
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            softrst_q       <= 1'b0;
            throttle_q      <= 1'b0;
            intr_q          <= 1'b0;
            overrun_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q         <= state_d;
            softrst_q       <= softrst_d;
            throttle_q      <= throttle_d;
            intr_q          <= intr_d;
            overrun_count_q <= overrun_count_d;
        end
    end

    assign quota_softrst_o = softrst_q;
    assign throttle_o      = throttle_q;
    assign intr_o          = intr_q;
    assign overrun_count_o = overrun_count_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_pmu_quota_regulator.sv
// Self-checking bench for pmu_quota_regulator: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a window model.
module tb_pmu_quota_regulator;

    localparam int RW      = 32;
    localparam int CW      = 8;
    localparam int OVR_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_i, enable_i, intr_quota_i, ack_i;
    logic [RW-1:0] period_i;
    logic          quota_softrst_o, throttle_o, intr_o;
    logic [CW-1:0] overrun_count_o;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    pmu_quota_regulator #(.REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .period_i        (period_i),
        .intr_quota_i    (intr_quota_i),
        .ack_i           (ack_i),
        .quota_softrst_o (quota_softrst_o),
        .throttle_o      (throttle_o),
        .intr_o          (intr_o),
        .overrun_count_o (overrun_count_o),
        .state_o         (state_o)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // model: mode 0..3 and position inside the current window (0 = refill cycle)
    int m_mode = 0, m_pos = 0, m_len = 2, m_ovr = 0;
    bit m_intr = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ev = 1'b0;
        if (rst_i) begin
            m_mode = 0; m_pos = 0; m_ovr = 0; m_intr = 1'b0;
        end else begin
            if (!enable_i) begin
                m_mode = 0;
            end else begin
                case (m_mode)
                    0: m_mode = 1;
                    1: begin
                        m_len  = (period_i < 2) ? 2 : int'(period_i);
                        m_pos  = 1;
                        m_mode = 2;
                    end
                    2: begin
                        if (m_pos == m_len - 1) begin
                            m_mode = 1; ev = intr_quota_i;
                        end else begin
                            if (intr_quota_i) begin m_mode = 3; ev = 1'b1; end
                            m_pos++;
                        end
                    end
                    default: begin
                        if (m_pos == m_len - 1) m_mode = 1;
                        else m_pos++;
                    end
                endcase
            end
            if (ev) begin
                m_intr = 1'b1;
                if (m_ovr < OVR_MAX) m_ovr++;
            end else if (ack_i) begin
                m_intr = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",    state_o,         m_mode);
            chk("softrst",  quota_softrst_o, (m_mode == 1) ? 1 : 0);
            chk("throttle", throttle_o,      (m_mode == 3) ? 1 : 0);
            chk("intr",     intr_o,          m_intr);
            chk("overruns", overrun_count_o, m_ovr);
        end
    end

    initial begin
        int cnt;
        rst_i = 1'b1; enable_i = 1'b1; period_i = 32'd10; intr_quota_i = 1'b0; ack_i = 1'b0;

        // reset with enable held high
        repeat (3) step();
        chk_en = 1'b1;
        chk("rst_state", state_o, 0);
        chk("rst_outs", {quota_softrst_o, throttle_o, intr_o}, 0);
        chk("rst_cnt", overrun_count_o, 0);
        rst_i = 1'b0;
        step();
        chk("rel_state", state_o, 1);
        chk("rel_softrst", quota_softrst_o, 1);
        step();
        chk("rel_softrst_one", quota_softrst_o, 0);

        // steady refill
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (quota_softrst_o) cnt++;
        end
        chk("steady_pulses", cnt, 5);
        chk("steady_cnt", overrun_count_o, 0);

        // align to a refill, then overrun on the 4th run cycle
        cnt = 0;
        while (!quota_softrst_o && cnt < 20) begin step(); cnt++; end
        chk("align_refill", quota_softrst_o, 1);
        repeat (4) step();
        intr_quota_i = 1'b1;
        step();
        intr_quota_i = 1'b0;
        chk("thr_intr", intr_o, 1);
        chk("thr_cnt", overrun_count_o, 1);
        cnt = 0;
        while (throttle_o && cnt < 20) begin step(); cnt++; end
        chk("thr_len", cnt, 5);
        chk("thr_release", quota_softrst_o, 1);

        // overrun exactly at the window boundary
        repeat (9) step();
        intr_quota_i = 1'b1;
        step();
        intr_quota_i = 1'b0;
        chk("bnd_state", state_o, 1);
        chk("bnd_thr", throttle_o, 0);
        chk("bnd_cnt", overrun_count_o, 2);
        chk("bnd_intr", intr_o, 1);

        // ack alone, then ack colliding with an overrun
        step();
        ack_i = 1'b1;
        step();
        chk("ack_clear", intr_o, 0);
        intr_quota_i = 1'b1;
        step();
        ack_i = 1'b0; intr_quota_i = 1'b0;
        chk("ack_set_wins", intr_o, 1);
        chk("ack_thr", throttle_o, 1);
        chk("ack_cnt", overrun_count_o, 3);

        // disable while throttled
        enable_i = 1'b0;
        step();
        chk("dis_state", state_o, 0);
        chk("dis_thr", throttle_o, 0);
        chk("dis_cnt", overrun_count_o, 3);
        enable_i = 1'b1;
        period_i = 32'd0;
        step();
        step();
        chk("p0_run", state_o, 2);
        step();
        chk("p0_refill", quota_softrst_o, 1);

        // saturate the counter with back-to-back boundary overruns
        intr_quota_i = 1'b1;
        repeat (2 * OVR_MAX + 4) step();
        chk("sat_cnt", overrun_count_o, OVR_MAX);
        repeat (2) step();
        chk("sat_hold", overrun_count_o, OVR_MAX);
        intr_quota_i = 1'b0;

        // randomized traffic with occasional mid-operation reset
        rst_i = 1'b1;
        step();
        for (int i = 0; i < 4000; i++) begin
            rst_i        = ($urandom_range(0, 199) == 0);
            enable_i     = ($urandom_range(0, 39) != 0);
            period_i     = $urandom_range(0, 12);
            intr_quota_i = ($urandom_range(0, 4) == 0);
            ack_i        = ($urandom_range(0, 9) == 0);
            step();
        end

        chk_en = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pmu_quota_regulator.md
# pmu_quota_regulator

Per-core quota regulator in the PMU: the control-side counterpart of the quota monitor. It consumes the monitor's quota-exceeded interrupt and closes the loop. It replenishes the budget every programmable period by soft-resetting the monitor. It throttles the core once the budget is exhausted, until the next period boundary. It raises a host interrupt and keeps a saturating count of overrun periods.

## Interface
- REG_WIDTH, 32, width of period register and internal timer
- CNT_WIDTH, 16, width of overrun counter
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  regulator enable (level)
- period_i  in  REG_WIDTH  replenishment window length in cycles; sampled only in REFILL
- intr_quota_i  in  1  quota-exceeded level from quota monitor
- ack_i  in  1  host acknowledge; clears intr_o
- quota_softrst_o  out  1  soft reset to quota monitor; one-cycle pulse per window
- throttle_o  out  1  stall request to core
- intr_o  out  1  sticky host interrupt
- overrun_count_o  out  CNT_WIDTH  saturating count of windows in which quota was exceeded
- state_o  out  2  current FSM state (debug)

## Operation
- FSM states: IDLE=0, REFILL=1, RUN=2, THROTTLED=3.
- IDLE: all control outputs 0. enable_i=1 -> REFILL.
- REFILL (exactly 1 cycle): quota_softrst_o=1. Timer loads max(period_i,2)-2. -> RUN.
- RUN, evaluated in priority order:
  - timer==0 -> REFILL. If intr_quota_i=1 in that same cycle, still count an overrun and set intr_o, but do not throttle.
  - else intr_quota_i=1 -> THROTTLED, count overrun, set intr_o.
  - else decrement timer.
- THROTTLED: throttle_o=1; intr_quota_i ignored; timer keeps decrementing; timer==0 -> REFILL.
- enable_i=0 in any state -> IDLE next cycle. Overrides all other transitions. Timer is frozen. intr_o and overrun_count_o are retained.
- intr_quota_i is ignored in IDLE, REFILL and THROTTLED.
- Window length: exactly max(period_i,2) cycles, counting the REFILL cycle. period_i values 0 and 1 behave as 2.
- overrun_count_o: +1 per overrun event; saturates at all-ones; cleared only by rst_i.
- intr_o: set on an overrun event; cleared by ack_i. If set and ack occur in the same cycle, set wins.
- Timer arithmetic: unsigned REG_WIDTH. It never underflows because the timer==0 check precedes the decrement.

## Timing
- All outputs are registered and decoded from the next state. An output changes in the cycle after the state-changing inputs are sampled.
- Reset values: state_o=IDLE, quota_softrst_o=0, throttle_o=0, intr_o=0, overrun_count_o=0, timer=0.
- rst_i mid-operation: returns to IDLE on the next edge, all outputs 0. rst_i has priority over enable_i.
- Throttle latency: intr_quota_i sampled high in RUN -> throttle_o=1 and intr_o=1 on the next cycle.
- Release: throttle_o falls in the same cycle quota_softrst_o rises (REFILL).
- quota_softrst_o is high for exactly one cycle per window. The monitor is cleared at the edge ending REFILL, so intr_quota_i is valid from the first RUN cycle.
- First REFILL follows enable_i=1 by one cycle (IDLE -> REFILL).

## Structure
- Shared package pmu_quota_pkg holds:
  - typedef enum logic [1:0] quota_reg_state_t (IDLE, REFILL, RUN, THROTTLED);
  - constant MIN_PERIOD=2.
- One sub-module, pmu_period_timer: loadable REG_WIDTH down-counter with load, dec and zero outputs. The FSM, overrun counter and interrupt logic stay in the top.

## Test plan
- Reset: rst_i=1 for 3 cycles with enable_i=1 -> all outputs 0, state_o=0. Release -> state_o=1 and quota_softrst_o=1 for exactly one cycle, starting the cycle after release.
- Steady refill: period_i=10, intr_quota_i=0 for 50 cycles -> quota_softrst_o pulses every 10 cycles; throttle_o, intr_o and overrun_count_o stay 0.
- Throttle: period_i=10, intr_quota_i=1 on the 4th RUN cycle -> throttle_o=1 from the next cycle until the next REFILL (5 cycles). intr_o=1, overrun_count_o=1, throttle_o=0 when quota_softrst_o=1.
- Boundary collision: intr_quota_i=1 exactly when timer==0 -> REFILL next cycle, throttle_o stays 0, overrun_count_o increments, intr_o=1.
- Ack: ack_i while intr_o=1 and no event -> intr_o=0 next cycle. ack_i coinciding with a new overrun -> intr_o stays 1.
- Edge cases, each checked separately:
  - enable_i=0 during THROTTLED -> IDLE and throttle_o=0 next cycle.
  - period_i=0 -> window of 2 cycles.
  - overrun_count_o preset to 0xFFFF by forcing overruns -> stays 0xFFFF on the next overrun.
